// File: rtl/mem_fetch_unit.sv
// Memory-side fetch/data stage: owns PC, IR and MDR and drives a 16-bit ready-handshake port.
// Optional per-beat wait timeout with sticky fault flag enabled by defining MEM_TIMEOUT_EN.
module mem_fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              irwrite,
  input  logic              iord,
  input  logic              memwrite,
  input  logic              pcen,
  input  logic              pcsrc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] pc,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              protocol_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_0 = 3'd1,
    FETCH_1 = 3'd2,
    DATA_RD = 3'd3,
    DATA_WR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] pc_tgt_q, pc_tgt_d;
  logic              pc_pend_q, pc_pend_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] pc_sel;
  logic              beat;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;
`endif

  assign pc_sel = pcsrc ? alu_out : alu_result;
  assign beat   = mem_req_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_tgt_d    = pc_tgt_q;
    pc_pend_d   = pc_pend_q;
    instr_d     = instr_q;
    mdr_d       = mdr_q;
    done_d      = 1'b0;
    perr_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = '0;
    fault_d     = fault_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (irwrite) begin
            // Fetch reads at the current PC; the PC update is deferred to fetch completion.
            state_d    = FETCH_0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
            pc_pend_d  = pcen;
            pc_tgt_d   = pc_sel;
            perr_d     = memwrite;
          end else begin
            if (pcen) begin
              pc_d = pc_sel;
            end
            if (iord && memwrite) begin
              state_d     = DATA_WR;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = alu_out;
              mem_wdata_d = wdata;
            end else if (iord) begin
              state_d    = DATA_RD;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = alu_out;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      FETCH_0: begin
        if (beat) begin
          instr_d[31:16] = mem_rdata;
          mem_addr_d     = pc_q + DATA_W'(2);
          state_d        = FETCH_1;
        end
      end
      FETCH_1: begin
        if (beat) begin
          instr_d[15:0] = mem_rdata;
          mem_req_d     = 1'b0;
          state_d       = IDLE;
          done_d        = 1'b1;
          pc_pend_d     = 1'b0;
          if (pc_pend_q) begin
            pc_d = pc_tgt_q;
          end
        end
      end
      DATA_RD: begin
        if (beat) begin
          mdr_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end
      end
      DATA_WR: begin
        if (beat) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    if (start && (state_q != IDLE)) begin
      perr_d = 1'b1;
    end

`ifdef MEM_TIMEOUT_EN
    // A beat that never completes is abandoned without touching PC/IR/MDR.
    if ((state_q != IDLE) && !beat) begin
      if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        done_d    = 1'b1;
        pc_pend_d = 1'b0;
        fault_d   = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_tgt_q    <= '0;
      pc_pend_q   <= 1'b0;
      instr_q     <= '0;
      mdr_q       <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_tgt_q    <= pc_tgt_d;
      pc_pend_q   <= pc_pend_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_fault = fault_q;
`else
  assign mem_fault = 1'b0;
`endif

  assign pc           = pc_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[31:26];
  assign funct        = instr_q[5:0];
  assign mdr          = mdr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign protocol_err = perr_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: halfword memory model with programmable ready delay.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, irwrite = 1'b0, iord = 1'b0, memwrite = 1'b0;
  logic        pcen = 1'b0, pcsrc = 1'b0;
  logic [15:0] alu_result = '0, alu_out = '0, wdata = '0;
  logic [15:0] pc, mdr, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic        busy, done, protocol_err, mem_req, mem_we, mem_ready, mem_fault;

  mem_fetch_unit #(.DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .irwrite(irwrite), .iord(iord),
    .memwrite(memwrite), .pcen(pcen), .pcsrc(pcsrc), .alu_result(alu_result),
    .alu_out(alu_out), .wdata(wdata), .pc(pc), .instr(instr), .opcode(opcode),
    .funct(funct), .mdr(mdr), .busy(busy), .done(done), .protocol_err(protocol_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Memory model: halfword array indexed by byte address bits [8:1].
  logic [15:0] mem [256];
  int          ready_delay = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;

  assign mem_rdata = mem[mem_addr[8:1]];
  assign mem_ready = mem_req && !stuck && (wcnt >= ready_delay);

  int          busy_cyc = 0, done_cnt = 0, perr_cnt = 0, we_cyc = 0, wr_cnt = 0, beats = 0;
  logic [15:0] beat_addr_prev = '0, beat_addr_last = '0, wr_addr = '0, wr_data = '0;
  logic        pend = 1'b0, pend_we = 1'b0, unstable = 1'b0;
  logic [15:0] pend_addr = '0, pend_wdata = '0;

  always @(posedge clk) begin
    if (busy)         busy_cyc <= busy_cyc + 1;
    if (done)         done_cnt <= done_cnt + 1;
    if (protocol_err) perr_cnt <= perr_cnt + 1;
    if (mem_we)       we_cyc   <= we_cyc + 1;
    if (rst) begin
      wcnt <= 0;
    end else if (mem_req && mem_ready) begin
      wcnt           <= 0;
      beats          <= beats + 1;
      beat_addr_prev <= beat_addr_last;
      beat_addr_last <= mem_addr;
      if (mem_we) begin
        mem[mem_addr[8:1]] = mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
    if (pend && (!mem_req || mem_addr != pend_addr || mem_we != pend_we || mem_wdata != pend_wdata))
      unstable <= 1'b1;
    pend       <= mem_req && !mem_ready;
    pend_addr  <= mem_addr;
    pend_we    <= mem_we;
    pend_wdata <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int b_busy, b_done, b_perr, b_we, b_wr, b_beats;

  task automatic do_cmd(input logic irw, input logic io, input logic mw, input logic pe,
                        input logic ps, input logic [15:0] ar, input logic [15:0] ao,
                        input logic [15:0] wd, input int dly, input int restart_after);
    int n;
    @(negedge clk);
    ready_delay = dly;
    irwrite = irw; iord = io; memwrite = mw; pcen = pe; pcsrc = ps;
    alu_result = ar; alu_out = ao; wdata = wd;
    b_busy = busy_cyc; b_done = done_cnt; b_perr = perr_cnt;
    b_we = we_cyc; b_wr = wr_cnt; b_beats = beats;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0; pcen = 1'b0; pcsrc = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (restart_after > 0 && n == restart_after) begin
        start = 1'b1; iord = 1'b1; memwrite = 1'b1;
      end else begin
        start = 1'b0; iord = 1'b0; memwrite = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; iord = 1'b0; memwrite = 1'b0;
    check("busy_bound", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h8C01;  // addr 0x0000
    mem[8'h01] = 16'h0004;  // addr 0x0002
    mem[8'h02] = 16'h0123;  // addr 0x0004
    mem[8'h03] = 16'h4567;  // addr 0x0006
    mem[8'h08] = 16'hBEEF;  // addr 0x0010
    mem[8'h11] = 16'h5678;  // addr 0x0022
    mem[8'hFF] = 16'hCAFE;  // addr 0xFFFE

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pc", {16'd0, pc}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mdr", {16'd0, mdr}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_perr", {31'd0, protocol_err}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'h0);
    check("rst_fault", {31'd0, mem_fault}, 32'd0);

    // Fetch at pc=0 with PC+4 update.
    do_cmd(1, 0, 0, 1, 0, 16'h0004, 16'h0000, 16'h0000, 0, 0);
    check("f1_instr", instr, 32'h8C010004);
    check("f1_opcode", {26'd0, opcode}, 32'h23);
    check("f1_funct", {26'd0, funct}, 32'h04);
    check("f1_pc", {16'd0, pc}, 32'h0004);
    check("f1_busy", busy_cyc - b_busy, 2);
    check("f1_done", done_cnt - b_done, 1);
    check("f1_perr", perr_cnt - b_perr, 0);
    check("f1_beat0", {16'd0, beat_addr_prev}, 32'h0000);
    check("f1_beat1", {16'd0, beat_addr_last}, 32'h0002);

    // Fetch with 3 wait cycles per beat.
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3, 0);
    check("f2_instr", instr, 32'h01234567);
    check("f2_busy", busy_cyc - b_busy, 8);
    check("f2_pc", {16'd0, pc}, 32'h0004);
    check("f2_beat0", {16'd0, beat_addr_prev}, 32'h0004);
    check("f2_beat1", {16'd0, beat_addr_last}, 32'h0006);
    check("f2_stable", {31'd0, unstable}, 32'd0);

    // Load.
    do_cmd(0, 1, 0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 0);
    check("ld_mdr", {16'd0, mdr}, 32'hBEEF);
    check("ld_we", we_cyc - b_we, 0);
    check("ld_pc", {16'd0, pc}, 32'h0004);
    check("ld_busy", busy_cyc - b_busy, 1);
    check("ld_done", done_cnt - b_done, 1);

    // Store.
    do_cmd(0, 1, 1, 0, 0, 16'h0000, 16'h0020, 16'h1234, 0, 0);
    check("st_writes", wr_cnt - b_wr, 1);
    check("st_addr", {16'd0, wr_addr}, 32'h0020);
    check("st_data", {16'd0, wr_data}, 32'h1234);
    check("st_busy", busy_cyc - b_busy, 1);
    check("st_mem", {16'd0, mem[8'h10]}, 32'h1234);

    // irwrite with memwrite: fetch proceeds, write dropped, branch-target PC.
    do_cmd(1, 1, 1, 1, 1, 16'h0000, 16'h0020, 16'hAAAA, 0, 0);
    check("iw_perr", perr_cnt - b_perr, 1);
    check("iw_writes", wr_cnt - b_wr, 0);
    check("iw_instr", instr, 32'h01234567);
    check("iw_pc", {16'd0, pc}, 32'h0020);

    // start while busy during a slow fetch.
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0030, 16'h9999, 3, 2);
    check("bz_perr", perr_cnt - b_perr, 1);
    check("bz_writes", wr_cnt - b_wr, 0);
    check("bz_instr", instr, 32'h12345678);
    check("bz_busy", busy_cyc - b_busy, 8);
    check("bz_done", done_cnt - b_done, 1);

    // No memory operation: PC loads at start, done next cycle.
    do_cmd(0, 0, 0, 1, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
    check("nm_pc", {16'd0, pc}, 32'hFFFE);
    check("nm_busy", busy_cyc - b_busy, 0);
    check("nm_done", done_cnt - b_done, 1);
    check("nm_beats", beats - b_beats, 0);

    // Fetch across the address wrap.
    do_cmd(1, 0, 0, 1, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0);
    check("wr_instr", instr, 32'hCAFE8C01);
    check("wr_beat0", {16'd0, beat_addr_prev}, 32'hFFFE);
    check("wr_beat1", {16'd0, beat_addr_last}, 32'h0000);
    check("wr_pc", {16'd0, pc}, 32'h0100);
    check("all_stable", {31'd0, unstable}, 32'd0);

    // Reset in the middle of FETCH_1.
    @(negedge clk);
    ready_delay = 3;
    irwrite = 1'b1; pcen = 1'b1; alu_result = 16'h0200;
    b_beats = beats;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; irwrite = 1'b0; pcen = 1'b0;
    for (int n = 0; n < 20 && beats == b_beats; n++) @(negedge clk);
    check("rm_beat0", beats - b_beats, 1);
    check("rm_addr", {16'd0, mem_addr}, 32'h0102);
    check("rm_pc_held", {16'd0, pc}, 32'h0100);
    rst = 1'b1;
    #1;
    check("rm_pc", {16'd0, pc}, 32'h0000);
    check("rm_instr", instr, 32'h0);
    check("rm_req", {31'd0, mem_req}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    stuck = 1'b1;
    do_cmd(0, 1, 0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 0);
    check("to_fault", {31'd0, mem_fault}, 32'd1);
    check("to_busy", busy_cyc - b_busy, 255);
    check("to_done", done_cnt - b_done, 1);
    check("to_mdr", {16'd0, mdr}, 32'h0);
    stuck = 1'b0;
`else
    check("no_fault", {31'd0, mem_fault}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
